meanshiftfiltering_mul_pipe: RTL



---
 rtl/meanshiftfiltering_mul_pipe.sv | 129 ++++++++++++
 1 files changed

// File: rtl/meanshiftfiltering_mul_pipe.sv
// Pipelined signed multiplier with round-half-up, arithmetic shift and
// saturation, valid/ready flow control and sticky overflow reporting.
module meanshiftfiltering_mul_pipe #(
    parameter int ID         = 1,
    parameter int NUM_STAGE  = 3,
    parameter int din0_WIDTH = 16,
    parameter int din1_WIDTH = 16,
    parameter int dout_WIDTH = 24,
    parameter int SHIFT      = 4
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic signed [din0_WIDTH-1:0] din0,
    input  logic signed [din1_WIDTH-1:0] din1,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic signed [dout_WIDTH-1:0] dout,
    output logic                         sat,
    output logic                         sat_sticky,
    input  logic                         clr
);

    localparam int W  = din0_WIDTH + din1_WIDTH;
    localparam int E  = ((W + 1 > dout_WIDTH) ? W + 1 : dout_WIDTH) + 1;
    localparam int RS = (SHIFT > 0) ? SHIFT - 1 : 0;

    localparam logic signed [E-1:0] MAXV =
        {{(E - dout_WIDTH + 1){1'b0}}, {(dout_WIDTH - 1){1'b1}}};
    localparam logic signed [E-1:0] MINV = ~MAXV;
    localparam logic signed [E-1:0] HALF =
        (SHIFT > 0) ? (E'(1) << RS) : '0;

    localparam int unused_id = ID;

    logic            adv;
    logic signed [W-1:0] prod;

    // Round/shift/clamp; result packed as {sat, value}.
    function automatic logic [dout_WIDTH:0] rnd_sat(
        input logic signed [W-1:0] p
    );
        logic signed [E-1:0] r;
        r = {{(E - W){p[W-1]}}, p};
        r = r + HALF;
        r = r >>> SHIFT;
        if (r > MAXV)
            rnd_sat = {1'b1, MAXV[dout_WIDTH-1:0]};
        else if (r < MINV)
            rnd_sat = {1'b1, MINV[dout_WIDTH-1:0]};
        else
            rnd_sat = {1'b0, r[dout_WIDTH-1:0]};
    endfunction

    assign prod     = din0 * din1;
    assign adv      = out_ready | ~out_valid;
    assign in_ready = adv;

    generate
        if (NUM_STAGE == 1) begin : g_one
            logic                         vld;
            logic signed [dout_WIDTH-1:0] res_q;
            logic                         sat_q;
            logic [dout_WIDTH:0]          rs;

            assign rs = rnd_sat(prod);

            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    vld   <= 1'b0;
                    res_q <= '0;
                    sat_q <= 1'b0;
                end else if (adv) begin
                    vld   <= in_valid;
                    res_q <= rs[dout_WIDTH-1:0];
                    sat_q <= rs[dout_WIDTH];
                end
            end

            assign out_valid = vld;
            assign dout      = res_q;
            assign sat       = sat_q;
        end else begin : g_multi
            logic [NUM_STAGE-1:0]         vld;
            logic signed [W-1:0]          prod_q;
            logic signed [dout_WIDTH-1:0] res_q [NUM_STAGE-1];
            logic [NUM_STAGE-2:0]         sat_q;
            logic [dout_WIDTH:0]          rs;

            assign rs = rnd_sat(prod_q);

            // Stage 1 holds the exact product; later stages carry results.
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    vld    <= '0;
                    prod_q <= '0;
                    sat_q  <= '0;
                    for (int i = 0; i < NUM_STAGE - 1; i++)
                        res_q[i] <= '0;
                end else if (adv) begin
                    vld      <= {vld[NUM_STAGE-2:0], in_valid};
                    prod_q   <= prod;
                    res_q[0] <= rs[dout_WIDTH-1:0];
                    sat_q[0] <= rs[dout_WIDTH];
                    for (int i = 1; i < NUM_STAGE - 1; i++) begin
                        res_q[i] <= res_q[i-1];
                        sat_q[i] <= sat_q[i-1];
                    end
                end
            end

            assign out_valid = vld[NUM_STAGE-1];
            assign dout      = res_q[NUM_STAGE-2];
            assign sat       = sat_q[NUM_STAGE-2];
        end
    endgenerate

    // Clear wins over a same-cycle saturated consume.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            sat_sticky <= 1'b0;
        else if (clr)
            sat_sticky <= 1'b0;
        else if (out_valid && out_ready && sat)
            sat_sticky <= 1'b1;
    end

endmodule
